// File: rtl/burger_video_pkg.sv
// Shared video types and defaults: 24-bit colour struct, the default stage
// palette and the play window size.
package burger_video_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  localparam rgb24_t BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};
  localparam rgb24_t WHITE = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
  localparam rgb24_t BLUE  = '{r: 8'h00, g: 8'h00, b: 8'hFF};
  localparam rgb24_t GREY  = '{r: 8'hB6, g: 8'hB6, b: 8'hAA};

  localparam int unsigned PLAY_W = 208;
  localparam int unsigned PLAY_H = 200;

  // Stage palette repeats every four entries when the index is wider than 2 bits.
  function automatic rgb24_t stage_default(input int unsigned entry);
    case (entry % 4)
      0:       return BLACK;
      1:       return WHITE;
      2:       return BLUE;
      default: return GREY;
    endcase
  endfunction

endpackage

// File: rtl/palette_ram.sv
// Per-layer palette register file: asynchronous read, one synchronous write
// port, and reset back to the default stage palette.
module palette_ram
  import burger_video_pkg::*;
#(
  parameter int unsigned LAYERS = 2,
  parameter int unsigned IDX_W  = 2,
  parameter int unsigned LW     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [LW-1:0]    wr_layer,
  input  logic [IDX_W-1:0] wr_addr,
  input  rgb24_t           wr_data,
  input  logic [LW-1:0]    rd_layer,
  input  logic [IDX_W-1:0] rd_addr,
  output rgb24_t           rd_data
);

  localparam int unsigned ENTRIES = 1 << IDX_W;

  rgb24_t mem [LAYERS][ENTRIES];

  // Out-of-range wr_layer matches no row, so such a write changes nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned l = 0; l < LAYERS; l++)
        for (int unsigned e = 0; e < ENTRIES; e++)
          mem[l][e] <= (l == 0) ? stage_default(e) : BLACK;
    end else if (we) begin
      for (int unsigned l = 0; l < LAYERS; l++)
        for (int unsigned e = 0; e < ENTRIES; e++)
          if (wr_layer == LW'(l) && wr_addr == IDX_W'(e))
            mem[l][e] <= wr_data;
    end
  end

  always_comb begin
    rd_data = BLACK;
    for (int unsigned l = 0; l < LAYERS; l++)
      if (rd_layer == LW'(l))
        rd_data = mem[l][rd_addr];
  end

endmodule

// File: rtl/layered_palette_mapper.sv
// Resolves layer priority/transparency, looks up the runtime palette and
// drives registered RGB; palette writes are held until blanking.
module layered_palette_mapper
  import burger_video_pkg::*;
#(
  parameter int unsigned LAYERS = 2,
  parameter int unsigned IDX_W  = 2,
  parameter int unsigned WIN_X0 = 0,
  parameter int unsigned WIN_Y0 = 0,
  parameter int unsigned WIN_W  = PLAY_W,
  parameter int unsigned WIN_H  = PLAY_H,
  localparam int unsigned LW    = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  input  logic                    blank,
  input  logic [LAYERS*IDX_W-1:0] layer_idx,
  input  logic [LAYERS-1:0]       layer_en,
  input  logic                    pal_valid,
  output logic                    pal_ready,
  input  logic [LW-1:0]           pal_layer,
  input  logic [IDX_W-1:0]        pal_addr,
  input  logic [23:0]             pal_rgb,
  output logic [7:0]              Red,
  output logic [7:0]              Green,
  output logic [7:0]              Blue
);

  logic [LW-1:0]    win_layer;
  logic [IDX_W-1:0] win_idx;
  logic [11:0]      dx, dy;
  logic             hit;

  // Layer 0 with idx!=0 picks itself anyway, so starting at 0 equals the fallback.
  always_comb begin
    win_layer = '0;
    win_idx   = layer_idx[IDX_W-1:0];
    for (int unsigned k = 0; k < LAYERS; k++)
      if (layer_en[k] && layer_idx[k*IDX_W +: IDX_W] != '0) begin
        win_layer = LW'(k);
        win_idx   = layer_idx[k*IDX_W +: IDX_W];
      end
  end

  // Offset form of the window test: bit 11 set means the pixel lies left/above.
  always_comb begin
    dx  = {2'b00, DrawX} - 12'(WIN_X0);
    dy  = {2'b00, DrawY} - 12'(WIN_Y0);
    hit = !dx[11] && (dx[10:0] < 11'(WIN_W)) &&
          !dy[11] && (dy[10:0] < 11'(WIN_H));
  end

  logic             s1_hit, s1_blank;
  logic [LW-1:0]    s1_layer;
  logic [IDX_W-1:0] s1_idx;
  rgb24_t           rd_rgb, rgb_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_hit   <= 1'b0;
      s1_blank <= 1'b1;
      s1_layer <= '0;
      s1_idx   <= '0;
      rgb_q    <= BLACK;
    end else begin
      s1_hit   <= hit;
      s1_blank <= blank;
      s1_layer <= win_layer;
      s1_idx   <= win_idx;
      rgb_q    <= (s1_hit && !s1_blank) ? rd_rgb : BLACK;
    end
  end

  logic             pending, commit;
  logic [LW-1:0]    p_layer;
  logic [IDX_W-1:0] p_addr;
  rgb24_t           p_rgb;

  assign pal_ready = !pending;
  assign commit    = pending && s1_blank;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pending <= 1'b0;
      p_layer <= '0;
      p_addr  <= '0;
      p_rgb   <= BLACK;
    end else if (commit) begin
      pending <= 1'b0;
    end else if (pal_valid && !pending) begin
      pending <= 1'b1;
      p_layer <= pal_layer;
      p_addr  <= pal_addr;
      p_rgb   <= pal_rgb;
    end
  end

  palette_ram #(
    .LAYERS (LAYERS),
    .IDX_W  (IDX_W),
    .LW     (LW)
  ) u_palette (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .we       (commit),
    .wr_layer (p_layer),
    .wr_addr  (p_addr),
    .wr_data  (p_rgb),
    .rd_layer (s1_layer),
    .rd_addr  (s1_idx),
    .rd_data  (rd_rgb)
  );

  assign Red   = rgb_q.r;
  assign Green = rgb_q.g;
  assign Blue  = rgb_q.b;

endmodule

// File: tb/tb_layered_palette_mapper.sv
// Randomised scoreboard bench for layered_palette_mapper (three layers so an
// out-of-range pal_layer is representable).
module tb_layered_palette_mapper;

  localparam int unsigned LAYERS = 3;
  localparam int unsigned IDX_W  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  draw_x, draw_y;
  logic        blank;
  logic [5:0]  layer_idx;
  logic [2:0]  layer_en;
  logic        pal_valid, pal_ready;
  logic [1:0]  pal_layer, pal_addr;
  logic [23:0] pal_rgb;
  logic [7:0]  red, green, blue;

  always #5 clk = ~clk;

  layered_palette_mapper #(
    .LAYERS (LAYERS),
    .IDX_W  (IDX_W),
    .WIN_X0 (0),
    .WIN_Y0 (0),
    .WIN_W  (208),
    .WIN_H  (200)
  ) dut (
    .Clk       (clk),
    .Reset_n   (rst_n),
    .DrawX     (draw_x),
    .DrawY     (draw_y),
    .blank     (blank),
    .layer_idx (layer_idx),
    .layer_en  (layer_en),
    .pal_valid (pal_valid),
    .pal_ready (pal_ready),
    .pal_layer (pal_layer),
    .pal_addr  (pal_addr),
    .pal_rgb   (pal_rgb),
    .Red       (red),
    .Green     (green),
    .Blue      (blue)
  );

  typedef struct {
    int unsigned due;
    logic [23:0] rgb;
    int unsigned x;
    int unsigned y;
  } exp_t;

  typedef struct {
    logic [1:0]  layer;
    logic [1:0]  addr;
    logic [23:0] rgb;
  } wr_t;

  exp_t q[$];
  wr_t  wq[$];
  exp_t mon_e;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned edge_cnt = 0;

  logic [23:0] mpal [LAYERS][4];
  bit          m_pending;
  int unsigned m_player, m_paddr;
  logic [23:0] m_prgb;
  bit          m_s1_blank;

  function automatic logic [23:0] ref_default(input int unsigned e);
    logic [23:0] tbl [4];
    tbl = '{24'h000000, 24'hFFFFFF, 24'h0000FF, 24'hB6B6AA};
    return tbl[e];
  endfunction

  task automatic model_reset();
    for (int l = 0; l < LAYERS; l++)
      for (int e = 0; e < 4; e++)
        mpal[l][e] = (l == 0) ? ref_default(e) : 24'h0;
    m_pending  = 0;
    m_s1_blank = 1;
    q.delete();
  endtask

  function automatic logic [23:0] expect_pixel(input int unsigned x, input int unsigned y,
                                               input bit b, input logic [5:0] iv,
                                               input logic [2:0] en);
    int unsigned idx;
    if (b || x >= 208 || y >= 200) return 24'h0;
    for (int k = LAYERS - 1; k >= 1; k--) begin
      idx = (int'(iv) >> (k * IDX_W)) & 3;
      if (en[k] && idx != 0) return mpal[k][idx];
    end
    return mpal[0][int'(iv) & 3];
  endfunction

  // Reference model: palette contents, deferred-write slot and expected pixel stream.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      edge_cnt++;
      if (m_pending && m_s1_blank) begin
        if (m_player < LAYERS) mpal[m_player][m_paddr] = m_prgb;
        m_pending = 0;
      end else if (pal_valid && !m_pending) begin
        m_pending = 1;
        m_player  = pal_layer;
        m_paddr   = pal_addr;
        m_prgb    = pal_rgb;
      end
      m_s1_blank = blank;
      q.push_back('{edge_cnt + 1, expect_pixel(draw_x, draw_y, blank, layer_idx, layer_en),
                    draw_x, draw_y});
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      while (q.size() > 0 && q[0].due <= edge_cnt) begin
        mon_e = q.pop_front();
        vectors++;
        if ({red, green, blue} !== mon_e.rgb) begin
          miscompares++;
          $display("FAIL rgb x=%0d y=%0d got %06h expected %06h",
                   mon_e.x, mon_e.y, {red, green, blue}, mon_e.rgb);
        end
      end
      vectors++;
      if (pal_ready !== !m_pending) begin
        miscompares++;
        $display("FAIL pal_ready at edge %0d got %0b expected %0b", edge_cnt, pal_ready, !m_pending);
      end
    end
  end

  task automatic step(input int unsigned x, input int unsigned y, input bit b,
                      input logic [5:0] iv, input logic [2:0] en);
    @(negedge clk);
    draw_x    = 10'(x);
    draw_y    = 10'(y);
    blank     = b;
    layer_idx = iv;
    layer_en  = en;
    if (wq.size() > 0) begin
      pal_valid = 1'b1;
      pal_layer = wq[0].layer;
      pal_addr  = wq[0].addr;
      pal_rgb   = wq[0].rgb;
      if (pal_ready) void'(wq.pop_front());
    end else begin
      pal_valid = 1'b0;
    end
  endtask

  task automatic rnd_step(input bit b, input bit in_win);
    int unsigned x, y;
    x = in_win ? $urandom_range(0, 207) : $urandom_range(0, 260);
    y = in_win ? $urandom_range(0, 199) : $urandom_range(0, 240);
    step(x, y, b, 6'($urandom), 3'($urandom));
  endtask

  task automatic push_wr(input logic [1:0] l, input logic [1:0] a, input logic [23:0] c);
    wq.push_back('{l, a, c});
  endtask

  bit rb;

  initial begin
    rst_n = 1'b0; draw_x = '0; draw_y = '0; blank = 1'b1;
    layer_idx = '0; layer_en = '0; pal_valid = 1'b0;
    pal_layer = '0; pal_addr = '0; pal_rgb = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    step(10, 10, 0, 6'b00_00_11, 3'b000);
    step(10, 10, 0, 6'b00_00_01, 3'b000);

    push_wr(2'd1, 2'd2, 24'hFF0000);
    repeat (4) step(0, 0, 1, 6'h0, 3'b000);
    step(50, 50, 0, 6'b00_10_01, 3'b011);
    step(50, 50, 0, 6'b00_10_01, 3'b001);
    step(50, 50, 0, 6'b00_00_01, 3'b011);
    step(50, 50, 0, 6'b01_10_10, 3'b111);

    step(207, 20, 0, 6'b00_00_01, 3'b000);
    step(208, 20, 0, 6'b00_00_01, 3'b000);
    step(20, 199, 0, 6'b00_00_01, 3'b000);
    step(20, 200, 0, 6'b00_00_01, 3'b000);
    step(20, 20, 1, 6'b00_00_01, 3'b000);
    step(1023, 1023, 0, 6'b00_00_01, 3'b000);

    push_wr(2'd0, 2'd1, 24'h00FF00);
    repeat (10) step(30, 30, 0, 6'b00_00_01, 3'b000);
    repeat (3) step(300, 30, 1, 6'h0, 3'b000);
    repeat (3) step(30, 30, 0, 6'b00_00_01, 3'b000);

    push_wr(2'd2, 2'd3, 24'h123456);
    push_wr(2'd1, 2'd1, 24'h654321);
    push_wr(2'd3, 2'd2, 24'hABCDEF);
    repeat (10) step(0, 0, 1, 6'h0, 3'b000);
    step(40, 40, 0, 6'b11_00_00, 3'b100);
    step(40, 40, 0, 6'b00_01_00, 3'b010);
    step(40, 40, 0, 6'b00_00_10, 3'b000);

    rb = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) rb = !rb;
      if ($urandom_range(0, 19) == 0 && wq.size() < 2)
        push_wr(2'($urandom), 2'($urandom), 24'($urandom));
      rnd_step(rb, $urandom_range(0, 3) != 0);
    end

    repeat (2) step(60, 60, 0, 6'h0, 3'b000);
    push_wr(2'd0, 2'd2, 24'h777777);
    repeat (3) step(60, 60, 0, 6'b00_00_10, 3'b000);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({red, green, blue} !== 24'h0 || pal_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset rgb=%06h ready=%0b expected rgb=000000 ready=1",
               {red, green, blue}, pal_ready);
    end
    wq.delete();
    pal_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(60, 60, 1, 6'h0, 3'b000);
    repeat (4) step(60, 60, 0, 6'b00_00_10, 3'b000);
    for (int i = 0; i < 300; i++) rnd_step($urandom_range(0, 7) == 0, 1);
    repeat (3) step(0, 0, 1, 6'h0, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
